// File: rtl/ddr3_cmd_pkg.sv
// Purpose: shared DDR3 command encodings, controller state enum and default timing values.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ddr3_cmd_pkg;

    // Command pin bundle, ordered {CS_n, RAS_n, CAS_n, WE_n}
    typedef logic [3:0] ddr3_cmd_t;

    localparam ddr3_cmd_t CMD_NOP = 4'b0111;
    localparam ddr3_cmd_t CMD_ACT = 4'b0011;
    localparam ddr3_cmd_t CMD_RD  = 4'b0101;
    localparam ddr3_cmd_t CMD_PRE = 4'b0010;
    localparam ddr3_cmd_t CMD_DES = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        ACT,
        TRCD_WAIT,
        RD,
        CL_WAIT,
        BURST,
        PRE,
        TRP_WAIT
    } rd_state_t;

    // Default timings, also used by the write command FSM
    localparam int DEF_TRCD  = 5;
    localparam int DEF_CL    = 5;
    localparam int DEF_TRP   = 5;
    localparam int DEF_BEATS = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ddr3_wait_counter.sv
// Purpose: loadable down-counter with zero flag, shared by all timed controller phases.
// Latency: load/decrement take effect on the next clk; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
// Ports: clk, areset_n; load + load_val reload the count; dec decrements; zero flags count == 0.
module ddr3_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ddr3_read_ctrl.sv
// Purpose: DDR3 read command sequencer (ACT -> RD[/AP] -> PRE) with burst capture from the PHY.
// Latency: ACT 1 clk after accept, RD TRCD later, first word out CL+1 after RD, done TRP after PRE.
// Backpressure: req_ready low while a read is in flight; one request per handshake.
// Ports: req_* / rd_row/col/bank/ap request side; DQ_in PHY data; CS_n/RAS_n/CAS_n/WE_n/CKE/ODT,
//        Addr_out, BA_out command pins; rd_data/rd_data_valid captured words; rd_done completion.
module ddr3_read_ctrl
    import ddr3_cmd_pkg::*;
#(
    parameter int TRCD  = DEF_TRCD,
    parameter int CL    = DEF_CL,
    parameter int TRP   = DEF_TRP,
    parameter int BEATS = DEF_BEATS
) (
    input  logic        clk,
    input  logic        areset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [14:0] rd_row,
    input  logic [9:0]  rd_col,
    input  logic [2:0]  rd_bank,
    input  logic        rd_ap,
    input  logic [15:0] DQ_in,
    output logic        CS_n,
    output logic        RAS_n,
    output logic        CAS_n,
    output logic        WE_n,
    output logic        CKE,
    output logic        ODT,
    output logic [14:0] Addr_out,
    output logic [2:0]  BA_out,
    output logic [15:0] rd_data,
    output logic        rd_data_valid,
    output logic        rd_done
);

    // The counter holds (cycles remaining in the phase - 1) so the exit cycle is the one
    // where it reads zero. Largest preload is below CNT_MAX.
    localparam int CNT_MAX = max4(TRCD, CL, TRP, BEATS);
    localparam int CW      = (CNT_MAX <= 2) ? 1 : $clog2(CNT_MAX);

    // TRCD_WAIT/CL_WAIT last one cycle less than the timing (ACT/RD cycle counts as the first)
    localparam logic [CW-1:0] LD_TRCD    = CW'((TRCD >= 2) ? TRCD - 2 : 0);
    localparam logic [CW-1:0] LD_CL      = CW'((CL >= 2) ? CL - 2 : 0);
    localparam logic [CW-1:0] LD_BEATS   = CW'(BEATS - 1);
    localparam logic [CW-1:0] LD_TRP_PRE = CW'((TRP >= 2) ? TRP - 2 : 0);
    // With auto-precharge there is no PRE cycle, so the full TRP is spent waiting
    localparam logic [CW-1:0] LD_TRP_AP  = CW'(TRP - 1);

    rd_state_t       state_q, state_d;
    ddr3_cmd_t       cmd_q;
    logic [9:0]      col_q;
    logic [2:0]      bank_q;
    logic            ap_q;
    logic            cnt_load;
    logic [CW-1:0]   cnt_load_val;
    logic            cnt_dec;
    logic            cnt_zero;
    logic            accept;

    assign accept = (state_q == IDLE) && req_valid && req_ready;

    ddr3_wait_counter #(.W(CW)) u_wait_cnt (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACT;
            end
            ACT: begin
                if (TRCD == 1) begin
                    state_d = RD;
                end else begin
                    state_d      = TRCD_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_TRCD;
                end
            end
            TRCD_WAIT: begin
                if (cnt_zero) state_d = RD;
                else          cnt_dec = 1'b1;
            end
            RD: begin
                cnt_load = 1'b1;
                if (CL == 1) begin
                    state_d      = BURST;
                    cnt_load_val = LD_BEATS;
                end else begin
                    state_d      = CL_WAIT;
                    cnt_load_val = LD_CL;
                end
            end
            CL_WAIT: begin
                if (cnt_zero) begin
                    state_d      = BURST;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_BEATS;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            BURST: begin
                if (cnt_zero) begin
                    if (ap_q) begin
                        state_d      = TRP_WAIT;
                        cnt_load     = 1'b1;
                        cnt_load_val = LD_TRP_AP;
                    end else begin
                        state_d = PRE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            PRE: begin
                if (TRP == 1) begin
                    state_d = IDLE;
                end else begin
                    state_d      = TRP_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = LD_TRP_PRE;
                end
            end
            TRP_WAIT: begin
                if (cnt_zero) state_d = IDLE;
                else          cnt_dec = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are registered from the next state, so they line up with the state they describe.
    // ACT, RD and PRE are single-cycle states, so state_d == X means "entering X".
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= IDLE;
            cmd_q         <= CMD_DES;
            CKE           <= 1'b0;
            Addr_out      <= '0;
            BA_out        <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_done       <= 1'b0;
            req_ready     <= 1'b0;
            col_q         <= '0;
            bank_q        <= '0;
            ap_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            CKE           <= 1'b1;
            req_ready     <= (state_d == IDLE);
            rd_done       <= (state_d == IDLE) && (state_q != IDLE);
            rd_data_valid <= (state_q == BURST);
            if (state_q == BURST) rd_data <= DQ_in;

            if (accept) begin
                col_q  <= rd_col;
                bank_q <= rd_bank;
                ap_q   <= rd_ap;
            end

            case (state_d)
                ACT: begin
                    cmd_q    <= CMD_ACT;
                    Addr_out <= rd_row;
                    BA_out   <= rd_bank;
                end
                RD: begin
                    cmd_q    <= CMD_RD;
                    // A12 = 1 selects BL8 on the fly, A10 carries auto-precharge
                    Addr_out <= {2'b00, 1'b1, 1'b0, ap_q, col_q};
                    BA_out   <= bank_q;
                end
                PRE: begin
                    cmd_q        <= CMD_PRE;
                    Addr_out[10] <= 1'b0;
                    BA_out       <= bank_q;
                end
                default: cmd_q <= CMD_NOP;
            endcase
        end
    end

    assign {CS_n, RAS_n, CAS_n, WE_n} = cmd_q;
    assign ODT = 1'b0;

endmodule

// File: tb/tb_ddr3_read_ctrl.sv
// Purpose: directed self-checking bench for ddr3_read_ctrl (default timings plus a minimal-timing instance).
// Latency: cycle offsets k are counted from the accept cycle t (k = 1 is t+1).
// Backpressure: requests are only raised when req_ready is expected to be 1, except the busy-hold case.
`timescale 1ns/1ps
module tb_ddr3_read_ctrl;

    localparam int TRCD    = 5;
    localparam int CL      = 5;
    localparam int TRP     = 5;
    localparam int BEATS   = 8;
    localparam int K_RD    = 1 + TRCD;        // 6
    localparam int K_BURST = K_RD + CL;       // 11: first sampled cycle
    localparam int K_PRE   = K_BURST + BEATS; // 19
    localparam int K_DONE  = K_PRE + TRP;     // 24

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_DES = 4'b1111;

    logic clk = 1'b0;
    logic areset_n;
    always #5 clk = ~clk;

    // default-timing instance
    logic        req_valid, req_ready, rd_ap;
    logic [14:0] rd_row, addr_out;
    logic [9:0]  rd_col;
    logic [2:0]  rd_bank, ba_out;
    logic [15:0] dq_in, rd_data;
    logic        cs_n, ras_n, cas_n, we_n, cke, odt, rd_data_valid, rd_done;

    // minimal-timing instance
    logic        s_req_valid, s_req_ready, s_ap;
    logic [14:0] s_row, s_addr;
    logic [9:0]  s_col;
    logic [2:0]  s_bank, s_ba;
    logic [15:0] s_dq, s_rd_data;
    logic        s_cs_n, s_ras_n, s_cas_n, s_we_n, s_cke, s_odt, s_rdv, s_done;

    int n_cmp = 0;
    int n_bad = 0;

    ddr3_read_ctrl dut (
        .clk(clk), .areset_n(areset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .rd_row(rd_row), .rd_col(rd_col), .rd_bank(rd_bank), .rd_ap(rd_ap),
        .DQ_in(dq_in),
        .CS_n(cs_n), .RAS_n(ras_n), .CAS_n(cas_n), .WE_n(we_n), .CKE(cke), .ODT(odt),
        .Addr_out(addr_out), .BA_out(ba_out),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done)
    );

    ddr3_read_ctrl #(.TRCD(1), .CL(1), .TRP(1), .BEATS(1)) dut_min (
        .clk(clk), .areset_n(areset_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .rd_row(s_row), .rd_col(s_col), .rd_bank(s_bank), .rd_ap(s_ap),
        .DQ_in(s_dq),
        .CS_n(s_cs_n), .RAS_n(s_ras_n), .CAS_n(s_cas_n), .WE_n(s_we_n), .CKE(s_cke), .ODT(s_odt),
        .Addr_out(s_addr), .BA_out(s_ba),
        .rd_data(s_rd_data), .rd_data_valid(s_rdv), .rd_done(s_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // One full read on the default instance, starting in a cycle where req_ready is 1.
    // hold_busy keeps req_valid high with junk fields while the controller is busy.
    task automatic run_read(input logic [14:0] row, input logic [9:0] col, input logic [2:0] bank,
                            input logic ap, input logic [14:0] exp_rd_addr, input logic [15:0] base,
                            input logic hold_busy);
        logic [3:0] exp_cmd;
        logic       exp_v;
        chk("ready_at_req", 0, 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        rd_row    = row;
        rd_col    = col;
        rd_bank   = bank;
        rd_ap     = ap;
        for (int k = 1; k <= K_DONE; k++) begin
            step();
            if (hold_busy) begin
                req_valid = 1'b1;
                rd_row    = 15'h5555;
                rd_col    = 10'h2AA;
                rd_bank   = 3'd2;
                rd_ap     = ~ap;
            end else begin
                req_valid = 1'b0;
            end
            dq_in = (k >= K_BURST && k < K_PRE) ? base + 16'(k - K_BURST) : 16'hDEAD;
            exp_cmd = (k == 1)             ? C_ACT :
                      (k == K_RD)          ? C_RD  :
                      (k == K_PRE && !ap)  ? C_PRE : C_NOP;
            chk("cmd", k, 32'({cs_n, ras_n, cas_n, we_n}), 32'(exp_cmd));
            if (k == 1) begin
                chk("act_addr", k, 32'(addr_out), 32'(row));
                chk("act_ba", k, 32'(ba_out), 32'(bank));
            end
            if (k == K_RD) begin
                chk("rd_addr", k, 32'(addr_out), 32'(exp_rd_addr));
                chk("rd_ba", k, 32'(ba_out), 32'(bank));
            end
            if (k == K_PRE && !ap) begin
                chk("pre_a10", k, 32'(addr_out[10]), 32'(0));
                chk("pre_ba", k, 32'(ba_out), 32'(bank));
            end
            exp_v = (k > K_BURST && k <= K_PRE);
            chk("rd_valid", k, 32'(rd_data_valid), 32'(exp_v));
            if (exp_v) chk("rd_data", k, 32'(rd_data), 32'(base + 16'(k - K_BURST - 1)));
            chk("rd_done", k, 32'(rd_done), 32'(k == K_DONE));
            chk("req_ready", k, 32'(req_ready), 32'(k == K_DONE));
        end
    endtask

    initial begin
        req_valid = 1'b0; rd_row = '0; rd_col = '0; rd_bank = '0; rd_ap = 1'b0; dq_in = '0;
        s_req_valid = 1'b0; s_row = '0; s_col = '0; s_bank = '0; s_ap = 1'b0; s_dq = '0;
        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        #2;

        // reset state
        chk("rst_cmd", 0, 32'({cs_n, ras_n, cas_n, we_n}), 32'(C_DES));
        chk("rst_cke", 0, 32'(cke), 32'(0));
        chk("rst_odt", 0, 32'(odt), 32'(0));
        chk("rst_addr", 0, 32'(addr_out), 32'(0));
        chk("rst_ba", 0, 32'(ba_out), 32'(0));
        chk("rst_data", 0, 32'(rd_data), 32'(0));
        chk("rst_valid", 0, 32'(rd_data_valid), 32'(0));
        chk("rst_done", 0, 32'(rd_done), 32'(0));
        chk("rst_ready", 0, 32'(req_ready), 32'(0));
        chk("rst_min_cmd", 0, 32'({s_cs_n, s_ras_n, s_cas_n, s_we_n}), 32'(C_DES));
        chk("rst_min_cke_odt", 0, 32'({s_cke, s_odt}), 32'(0));
        step();
        step();
        areset_n = 1'b1;
        chk("rel_ready_pre_edge", 0, 32'(req_ready), 32'(0));
        step();
        chk("rel_cke", 1, 32'(cke), 32'(1));
        chk("rel_ready", 1, 32'(req_ready), 32'(1));
        chk("rel_cmd_nop", 1, 32'({cs_n, ras_n, cas_n, we_n}), 32'(C_NOP));
        chk("rel_done", 1, 32'(rd_done), 32'(0));

        // 1: basic read with PRE
        run_read(15'h0123, 10'h045, 3'd3, 1'b0, 15'h1045, 16'hA000, 1'b0);
        // 2: auto-precharge
        run_read(15'h0123, 10'h045, 3'd3, 1'b1, 15'h1445, 16'hB000, 1'b0);
        // 3: request held during busy read; fields of the ready cycle win
        run_read(15'h0456, 10'h011, 3'd1, 1'b0, 15'h1011, 16'hC000, 1'b1);
        run_read(15'h0ABC, 10'h022, 3'd5, 1'b0, 15'h1022, 16'hC100, 1'b0);
        // 4: boundary addresses
        run_read(15'h7FFF, 10'h3FF, 3'd7, 1'b0, 15'h13FF, 16'hD000, 1'b0);

        // 5: reset during the 4th burst cycle (k = K_BURST + 3)
        req_valid = 1'b1; rd_row = 15'h0222; rd_col = 10'h033; rd_bank = 3'd2; rd_ap = 1'b0;
        for (int k = 1; k <= K_BURST + 3; k++) begin
            step();
            req_valid = 1'b0;
            dq_in = (k >= K_BURST) ? 16'hE000 + 16'(k - K_BURST) : 16'hDEAD;
        end
        chk("mid_valid_before_rst", K_BURST + 3, 32'(rd_data_valid), 32'(1));
        #2 areset_n = 1'b0;
        #1;
        chk("mid_rst_cmd", 0, 32'({cs_n, ras_n, cas_n, we_n}), 32'(C_DES));
        chk("mid_rst_cke", 0, 32'(cke), 32'(0));
        chk("mid_rst_valid", 0, 32'(rd_data_valid), 32'(0));
        chk("mid_rst_data", 0, 32'(rd_data), 32'(0));
        chk("mid_rst_ready", 0, 32'(req_ready), 32'(0));
        chk("mid_rst_addr", 0, 32'(addr_out), 32'(0));
        step();
        step();
        areset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("post_rst_done", k, 32'(rd_done), 32'(0));
            chk("post_rst_valid", k, 32'(rd_data_valid), 32'(0));
            chk("post_rst_cmd", k, 32'({cs_n, ras_n, cas_n, we_n}), 32'(C_NOP));
            chk("post_rst_ready", k, 32'(req_ready), 32'(1));
        end
        run_read(15'h0333, 10'h044, 3'd4, 1'b0, 15'h1044, 16'hF000, 1'b0);

        // 6: minimal timings: ACT t+1, RD t+2, sample t+3, PRE t+4, done t+5
        chk("min_ready", 0, 32'(s_req_ready), 32'(1));
        s_req_valid = 1'b1; s_row = 15'h0010; s_col = 10'h020; s_bank = 3'd6; s_ap = 1'b0;
        step();
        s_req_valid = 1'b0;
        chk("min_act", 1, 32'({s_cs_n, s_ras_n, s_cas_n, s_we_n}), 32'(C_ACT));
        chk("min_act_addr", 1, 32'(s_addr), 32'(15'h0010));
        chk("min_act_ba", 1, 32'(s_ba), 32'(6));
        chk("min_ready_busy", 1, 32'(s_req_ready), 32'(0));
        step();
        chk("min_rd", 2, 32'({s_cs_n, s_ras_n, s_cas_n, s_we_n}), 32'(C_RD));
        chk("min_rd_addr", 2, 32'(s_addr), 32'(15'h1020));
        step();
        s_dq = 16'h5A5A;
        chk("min_burst_nop", 3, 32'({s_cs_n, s_ras_n, s_cas_n, s_we_n}), 32'(C_NOP));
        chk("min_valid3", 3, 32'(s_rdv), 32'(0));
        step();
        s_dq = 16'h0000;
        chk("min_pre", 4, 32'({s_cs_n, s_ras_n, s_cas_n, s_we_n}), 32'(C_PRE));
        chk("min_pre_ba", 4, 32'(s_ba), 32'(6));
        chk("min_valid4", 4, 32'(s_rdv), 32'(1));
        chk("min_data4", 4, 32'(s_rd_data), 32'(16'h5A5A));
        chk("min_done4", 4, 32'(s_done), 32'(0));
        step();
        chk("min_done5", 5, 32'(s_done), 32'(1));
        chk("min_ready5", 5, 32'(s_req_ready), 32'(1));
        chk("min_valid5", 5, 32'(s_rdv), 32'(0));
        step();
        chk("min_done6", 6, 32'(s_done), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
